// File: rtl/pause_fade_ctrl.sv
// pause_fade_ctrl
//   Pauses the CPU on a button toggle, a level request or an open OSD, and
//   after a dwell time fades the video by right-shifting each colour channel
//   one step every FADE_FRAMES frames until MAX_SHIFT is reached.
//
// Ports
//   clk_sys        sole clock, rising edge
//   reset_n        synchronous active-low reset
//   user_button    pause toggle, acted on at its rising edge
//   pause_request  level pause requests, any bit high forces pause
//   OSD_STATUS     OSD open (level)
//   options        bit0 = pause while OSD open, bit1 = fade enable
//   vblank         vertical blank, rising edge is the frame boundary
//   rgb_in         {R,G,B} pixel data
//   pause_cpu      CPU halt (registered)
//   fade_level     current shift amount (registered)
//   rgb_out        faded pixel data, one cycle latency
//
// State   | meaning
// RUN     | CPU running, no fade
// PAUSED  | CPU halted, counting seconds toward the fade
// FADING  | stepping fade_level on frame boundaries
// FADED   | fade_level held at MAX_SHIFT
module pause_fade_ctrl #(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int NREQ        = 2,
  parameter int TICK_CYCLES = 24000000,
  parameter int DIM_SECONDS = 10,
  parameter int FADE_FRAMES = 4,
  parameter int MAX_SHIFT   = 2
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic                             user_button,
  input  logic [NREQ-1:0]                  pause_request,
  input  logic                             OSD_STATUS,
  input  logic [1:0]                       options,
  input  logic                             vblank,
  input  logic [RW+GW+BW-1:0]              rgb_in,
  output logic                             pause_cpu,
  output logic [$clog2(MAX_SHIFT+1)-1:0]   fade_level,
  output logic [RW+GW+BW-1:0]              rgb_out
);

  localparam int FW  = $clog2(MAX_SHIFT + 1);
  localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW  = $clog2(DIM_SECONDS + 1);
  localparam int FRW = $clog2(FADE_FRAMES + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0]  SEC_MAX    = SW'(DIM_SECONDS);
  localparam logic [FRW-1:0] FRAME_LAST = FRW'(FADE_FRAMES - 1);
  localparam logic [FW-1:0]  LVL_MAX    = FW'(MAX_SHIFT);

  typedef enum logic [1:0] {RUN, PAUSED, FADING, FADED} state_t;

  state_t         state, state_nxt;
  logic           btn_q, vb_q, pause_toggle, toggle_nxt;
  logic [PW-1:0]  presc, presc_nxt;
  logic [SW-1:0]  sec, sec_nxt;
  logic [FRW-1:0] frame, frame_nxt;
  logic [FW-1:0]  level_nxt, level_inc;
  logic           req_any, vb_rise;
  logic [RW-1:0]  r_s;
  logic [GW-1:0]  g_s;
  logic [BW-1:0]  b_s;

  // req_any uses the registered toggle, so a button edge affects the FSM
  // one cycle after the toggle flips.
  assign req_any   = pause_toggle | (|pause_request) | (options[0] & OSD_STATUS);
  assign vb_rise   = vblank & ~vb_q;
  assign level_inc = fade_level + FW'(1);

  always_comb begin
    toggle_nxt = pause_toggle ^ (user_button & ~btn_q);
    state_nxt  = state;
    presc_nxt  = presc;
    sec_nxt    = sec;
    frame_nxt  = frame;
    level_nxt  = fade_level;
    if (state == RUN) begin
      if (req_any) state_nxt = PAUSED;
    end else if (!req_any) begin
      state_nxt = RUN;
      presc_nxt = '0;
      sec_nxt   = '0;
      frame_nxt = '0;
      level_nxt = '0;
    end else begin
      case (state)
        PAUSED: begin
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            if (sec != SEC_MAX) sec_nxt = sec + SW'(1);
          end else begin
            presc_nxt = presc + PW'(1);
          end
          if (sec == SEC_MAX && options[1]) state_nxt = FADING;
        end
        FADING: begin
          if (!options[1]) begin
            state_nxt = PAUSED;
            frame_nxt = '0;
            level_nxt = '0;
          end else if (vb_rise) begin
            if (frame == FRAME_LAST) begin
              frame_nxt = '0;
              level_nxt = level_inc;
              if (level_inc == LVL_MAX) state_nxt = FADED;
            end else begin
              frame_nxt = frame + FRW'(1);
            end
          end
        end
        FADED: begin
          if (!options[1]) begin
            state_nxt = PAUSED;
            frame_nxt = '0;
            level_nxt = '0;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign r_s = rgb_in[RW+GW+BW-1 -: RW] >> fade_level;
  assign g_s = rgb_in[GW+BW-1 -: GW] >> fade_level;
  assign b_s = rgb_in[BW-1:0] >> fade_level;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state        <= RUN;
      btn_q        <= 1'b0;
      vb_q         <= 1'b0;
      pause_toggle <= 1'b0;
      presc        <= '0;
      sec          <= '0;
      frame        <= '0;
      fade_level   <= '0;
      pause_cpu    <= 1'b0;
      rgb_out      <= '0;
    end else begin
      state        <= state_nxt;
      btn_q        <= user_button;
      vb_q         <= vblank;
      pause_toggle <= toggle_nxt;
      presc        <= presc_nxt;
      sec          <= sec_nxt;
      frame        <= frame_nxt;
      fade_level   <= level_nxt;
      pause_cpu    <= (state_nxt != RUN);
      rgb_out      <= {r_s, g_s, b_s};
    end
  end

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Directed bench for pause_fade_ctrl with small timing parameters.
module tb_pause_fade_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_button;
  logic [1:0]  pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic        vblank;
  logic [23:0] rgb_in;
  logic        pause_cpu;
  logic [1:0]  fade_level;
  logic [23:0] rgb_out;

  int checks   = 0;
  int failures = 0;

  pause_fade_ctrl #(
    .RW(8), .GW(8), .BW(8), .NREQ(2),
    .TICK_CYCLES(10), .DIM_SECONDS(2), .FADE_FRAMES(2), .MAX_SHIFT(2)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .vblank        (vblank),
    .rgb_in        (rgb_in),
    .pause_cpu     (pause_cpu),
    .fade_level    (fade_level),
    .rgb_out       (rgb_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    user_button   = 1'b0;
    pause_request = 2'b00;
    OSD_STATUS    = 1'b0;
    options       = 2'b00;
    vblank        = 1'b0;
    rgb_in        = 24'hFF8040;
    tick(2);
    chk("rst_pause", 32'(pause_cpu), 32'd0);
    chk("rst_level", 32'(fade_level), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("run_rgb", 32'(rgb_out), 32'hFF8040);

    // button toggle: pause_cpu two edges after the press
    user_button = 1'b1; tick(); user_button = 1'b0;
    chk("btn1_e1", 32'(pause_cpu), 32'd0);
    tick();
    chk("btn1_e2", 32'(pause_cpu), 32'd1);
    user_button = 1'b1; tick(); user_button = 1'b0;
    chk("btn2_e1", 32'(pause_cpu), 32'd1);
    tick();
    chk("btn2_e2", 32'(pause_cpu), 32'd0);
    chk("btn2_lvl", 32'(fade_level), 32'd0);

    // OSD and external requests
    options = 2'b01; OSD_STATUS = 1'b1; tick();
    chk("osd_on", 32'(pause_cpu), 32'd1);
    options = 2'b00; tick();
    chk("osd_opt_off", 32'(pause_cpu), 32'd0);
    OSD_STATUS = 1'b0;
    pause_request = 2'b10; tick();
    chk("req_on", 32'(pause_cpu), 32'd1);
    tick(3);
    chk("req_hold", 32'(pause_cpu), 32'd1);
    pause_request = 2'b00; tick();
    chk("req_off", 32'(pause_cpu), 32'd0);

    // pause with fade enabled; vblank before the dwell expires must not fade
    options = 2'b10; rgb_in = 24'hFF8040;
    user_button = 1'b1; tick(); user_button = 1'b0; tick();
    chk("fade_paused", 32'(pause_cpu), 32'd1);
    vb_pulse(); vb_pulse();
    chk("dwell_nofade", 32'(fade_level), 32'd0);
    tick(21);
    vb_pulse();
    chk("fade_f1", 32'(fade_level), 32'd0);
    vb_pulse();
    chk("fade_lvl1", 32'(fade_level), 32'd1);
    chk("fade_rgb1", 32'(rgb_out), 32'h7F4020);
    vb_pulse(); vb_pulse();
    chk("fade_lvl2", 32'(fade_level), 32'd2);
    chk("fade_rgb2", 32'(rgb_out), 32'h3F2010);
    vb_pulse(); vb_pulse();
    chk("faded_hold", 32'(fade_level), 32'd2);
    chk("faded_pause", 32'(pause_cpu), 32'd1);

    // fade disable returns to PAUSED; re-enable fades again at once
    options = 2'b00; tick();
    chk("unfade_lvl", 32'(fade_level), 32'd0);
    chk("unfade_pause", 32'(pause_cpu), 32'd1);
    tick();
    chk("unfade_rgb", 32'(rgb_out), 32'hFF8040);
    options = 2'b10; tick();
    vb_pulse(); vb_pulse();
    chk("refade_lvl1", 32'(fade_level), 32'd1);
    vb_pulse(); vb_pulse();
    chk("refade_lvl2", 32'(fade_level), 32'd2);

    // reset while FADED
    reset_n = 1'b0; rgb_in = 24'h123456; tick();
    chk("mid_rst_pause", 32'(pause_cpu), 32'd0);
    chk("mid_rst_lvl", 32'(fade_level), 32'd0);
    chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
    reset_n = 1'b1; rgb_in = 24'hABCDEF; tick();
    chk("post_rst_rgb", 32'(rgb_out), 32'hABCDEF);
    tick();
    chk("post_rst_pause", 32'(pause_cpu), 32'd0);

    // button edge and request change in the same cycle
    options = 2'b00;
    user_button = 1'b1; pause_request = 2'b01; tick();
    chk("same_cyc_e1", 32'(pause_cpu), 32'd1);
    user_button = 1'b0; pause_request = 2'b00; tick();
    chk("same_cyc_toggle", 32'(pause_cpu), 32'd1);
    tick();
    chk("same_cyc_hold", 32'(pause_cpu), 32'd1);
    user_button = 1'b1; tick(); user_button = 1'b0;
    chk("same_cyc_un1", 32'(pause_cpu), 32'd1);
    tick();
    chk("same_cyc_un2", 32'(pause_cpu), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
